// File: rtl/gpio_irq_bank.sv
// gpio_irq_bank: GPIO bank with tri-state pads, synchronised inputs, edge-triggered sticky pending flags and one irq.
// Optional input debounce filter is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_irq_bank #(
   parameter int NUM_PINS        = 8,
   parameter int PIN_SEL_W       = 3,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PIN_SEL_W-1:0] pin_num,
   input  logic                 wr_bit,
   input  logic                 val_we,
   input  logic                 mode_we,
   input  logic                 ie_we,
   input  logic                 pol_we,
   input  logic                 ack_we,
   inout  wire  [NUM_PINS-1:0]  pins,
   output logic [NUM_PINS-1:0]  out,
   output logic [NUM_PINS-1:0]  pending,
   output logic                 irq
);
   logic [NUM_PINS-1:0] val_q, val_d, mode_q, mode_d, ie_q, ie_d, pol_q, pol_d;
   logic [NUM_PINS-1:0] pend_q, pend_d, hist_q, hist_d;
   logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q, sync_d;
   logic [NUM_PINS-1:0] sel, evt, cond;

`ifdef GPIO_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [NUM_PINS-1:0] cond_q, cond_d;
   logic [NUM_PINS-1:0][CW-1:0] cnt_q, cnt_d;
   // cond only follows the synced pad after it has disagreed for DEBOUNCE_CYCLES cycles in a row
   always_comb begin
      cond_d = cond_q;
      cnt_d  = cnt_q;
      for (int i = 0; i < NUM_PINS; i++) begin
         if (sync_q[SYNC_STAGES-1][i] == cond_q[i]) cnt_d[i] = '0;
         else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            cond_d[i] = sync_q[SYNC_STAGES-1][i];
            cnt_d[i]  = '0;
         end else cnt_d[i] = cnt_q[i] + CW'(1);
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cond_q <= '0;
         cnt_q  <= '0;
      end else begin
         cond_q <= cond_d;
         cnt_q  <= cnt_d;
      end
   end
   assign cond = cond_q;
`else
   assign cond = sync_q[SYNC_STAGES-1];
`endif

   always_comb begin
      for (int i = 0; i < NUM_PINS; i++) sel[i] = 32'(pin_num) == i;
      evt    = (pol_q & hist_q & ~cond) | (~pol_q & ~hist_q & cond);
      val_d  = val_we  ? (wr_bit ? val_q  | sel : val_q  & ~sel) : val_q;
      mode_d = mode_we ? (wr_bit ? mode_q | sel : mode_q & ~sel) : mode_q;
      ie_d   = ie_we   ? (wr_bit ? ie_q   | sel : ie_q   & ~sel) : ie_q;
      pol_d  = pol_we  ? (wr_bit ? pol_q  | sel : pol_q  & ~sel) : pol_q;
      // a new edge overrides a same-cycle acknowledge
      pend_d = (pend_q & ~(ack_we ? sel : '0)) | evt;
      hist_d = cond;
      sync_d = {sync_q[SYNC_STAGES-2:0], pins};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         val_q  <= '0;
         mode_q <= '0;
         ie_q   <= '0;
         pol_q  <= '0;
         pend_q <= '0;
         hist_q <= '0;
         sync_q <= '0;
      end else begin
         val_q  <= val_d;
         mode_q <= mode_d;
         ie_q   <= ie_d;
         pol_q  <= pol_d;
         pend_q <= pend_d;
         hist_q <= hist_d;
         sync_q <= sync_d;
      end
   end

   genvar i;
   for (i = 0; i < NUM_PINS; i++) begin : g_pad
      assign pins[i] = mode_q[i] ? val_q[i] : 1'bz;
   end

   assign out     = (mode_q & val_q) | (~mode_q & cond);
   assign pending = pend_q;
   assign irq     = |(pend_q & ie_q);
endmodule

// File: tb/tb_gpio_irq_bank.sv
// tb_gpio_irq_bank: directed checks of gpio_irq_bank with a 6-pin bank driven through per-pin pad drivers.
module tb_gpio_irq_bank;
   localparam int N = 6;
`ifdef GPIO_DEBOUNCE_EN
   localparam int LAT = 2 + 4;
`else
   localparam int LAT = 2;
`endif
   localparam logic [4:0] VAL = 5'b10000, MODE = 5'b01000, IE = 5'b00100, POL = 5'b00010, ACK = 5'b00001;

   logic clk = 0, reset, wr_bit, val_we, mode_we, ie_we, pol_we, ack_we;
   logic [2:0] pin_num;
   logic [N-1:0] tb_en, tb_val, out, pending;
   logic irq;
   wire  [N-1:0] pins;
   int cmp = 0, errs = 0;

   for (genvar g = 0; g < N; g++) begin : g_drv
      assign pins[g] = tb_en[g] ? tb_val[g] : 1'bz;
   end

   gpio_irq_bank #(.NUM_PINS(N), .PIN_SEL_W(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .pin_num(pin_num), .wr_bit(wr_bit), .val_we(val_we),
      .mode_we(mode_we), .ie_we(ie_we), .pol_we(pol_we), .ack_we(ack_we),
      .pins(pins), .out(out), .pending(pending), .irq(irq));

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] st, input logic [2:0] p, input logic b);
      {val_we, mode_we, ie_we, pol_we, ack_we} = st;
      pin_num = p;
      wr_bit = b;
      cyc(1);
      {val_we, mode_we, ie_we, pol_we, ack_we} = '0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1;
      {val_we, mode_we, ie_we, pol_we, ack_we} = '0;
      pin_num = '0;
      wr_bit = 0;
      tb_en = '1;
      tb_val = '0;
      #1;
      chk("rst_out", out, 0);
      chk("rst_pend", pending, 0);
      chk("rst_irq", irq, 0);
      cyc(3);
      reset = 0;
      cyc(LAT + 2);
      chk("idle_out", out, 0);
      chk("idle_pend", pending, 0);
      // pin3 as output driving 1
      wr(MODE, 3, 1);
      tb_en[3] = 0;
      chk("t1_pin3_lo", pins[3], 0);
      wr(VAL, 3, 1);
      chk("t1_pin3_hi", pins[3], 1);
      chk("t1_out", out, 6'b001000);
      cyc(LAT);
      chk("t1_pend_early", pending, 0);
      cyc(1);
      chk("t1_own_edge", pending, 6'b001000);
      chk("t1_irq_masked", irq, 0);
      wr(ACK, 3, 0);
      chk("t1_ack", pending, 0);
      // pin5 rising edge, latency, irq
      tb_val[5] = 1;
      cyc(LAT - 1);
      chk("t2_out_early", out[5], 0);
      cyc(1);
      chk("t2_out", out[5], 1);
      chk("t2_pend_early", pending, 0);
      cyc(1);
      chk("t2_pend", pending, 6'b100000);
      chk("t2_irq_off", irq, 0);
      wr(IE, 5, 1);
      chk("t2_irq_on", irq, 1);
      wr(ACK, 5, 0);
      chk("t2_ack_pend", pending, 0);
      chk("t2_ack_irq", irq, 0);
      // pin1 falling polarity
      wr(POL, 1, 1);
      tb_val[1] = 1;
      cyc(LAT + 2);
      chk("t3_rise_ignored", pending, 0);
      tb_val[1] = 0;
      cyc(LAT + 1);
      chk("t3_fall", pending, 6'b000010);
      tb_val[1] = 1;
      cyc(LAT + 2);
      chk("t3_sticky", pending, 6'b000010);
      chk("t3_irq", irq, 0);
      wr(ACK, 1, 0);
      // ack in the same cycle as a set on pin2
      tb_val[2] = 1;
      cyc(LAT);
      wr(ACK, 2, 0);
      chk("t4_set_wins", pending, 6'b000100);
      wr(IE, 2, 1);
      chk("t4_ie_set", irq, 1);
      wr(IE, 2, 0);
      chk("t4_ie_clr", irq, 0);
      wr(ACK, 2, 0);
      chk("t4_ack", pending, 0);
      // mode and value written together on pin4
      wr(VAL | MODE, 4, 1);
      tb_en[4] = 0;
      chk("ms_pin4", pins[4], 1);
      chk("ms_out", out, 6'b111110);
      cyc(LAT + 1);
      chk("ms_pend", pending, 6'b010000);
      wr(ACK, 4, 0);
      // out-of-range pin numbers
      wr(VAL | MODE | IE | POL | ACK, 7, 0);
      chk("oor7_out", out, 6'b111110);
      wr(VAL | MODE | IE | POL | ACK, 6, 0);
      chk("oor6_out", out, 6'b111110);
      chk("oor_pend", pending, 0);
      chk("oor_irq", irq, 0);
      // async reset in the middle of a write
      pin_num = 3;
      wr_bit = 0;
      val_we = 1;
      mode_we = 1;
      #3;
      tb_en[3] = 1;
      tb_en[4] = 1;
      tb_val[3] = 0;
      tb_val[4] = 0;
      reset = 1;
      #1;
      chk("mid_rst_out", out, 0);
      chk("mid_rst_pend", pending, 0);
      chk("mid_rst_irq", irq, 0);
      @(posedge clk);
      #1;
      chk("mid_rst_hold", out, 0);
      reset = 0;
      {val_we, mode_we, ie_we, pol_we, ack_we} = '0;
      cyc(LAT - 1);
      chk("post_rst_early", out, 0);
      cyc(1);
      chk("post_rst_out", out, 6'b100110);
      chk("post_rst_pend0", pending, 0);
      cyc(1);
      chk("post_rst_pend", pending, 6'b100110);
      chk("post_rst_irq", irq, 0);
`ifdef GPIO_DEBOUNCE_EN
      tb_val[0] = 1;
      cyc(2);
      tb_val[0] = 0;
      cyc(LAT + 2);
      chk("db_glitch_out", out[0], 0);
      chk("db_glitch_pend", pending[0], 0);
      tb_val[0] = 1;
      cyc(LAT - 1);
      chk("db_early", out[0], 0);
      cyc(1);
      chk("db_steady", out[0], 1);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule
